// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_checker
//  Description : Receive-side checker for a Fibonacci LFSR state stream.
//                Predicts each next state, flags and counts divergences,
//                and measures the period until the seed value recurs.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int                WIDTH = 64,
    parameter logic [WIDTH-1:0]  TAPS  = 64'hD800_0000_0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  seed,
    input  logic              start,
    input  logic              valid_in,
    input  logic [WIDTH-1:0]  data_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       err_count,
    output logic [WIDTH-1:0]  period,
    output logic              timeout
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_track = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [15:0] c_err_max = 16'hFFFF;

    // Next LFSR state: shift left, feedback parity of tapped bits into bit 0.
    function automatic logic [WIDTH-1:0] f_nxt(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WIDTH-1:0]  r_ref_seed;
    logic [WIDTH-1:0]  r_expected;
    logic [WIDTH-1:0]  r_count;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [15:0]       r_err_count;
    logic [WIDTH-1:0]  r_period;
    logic              r_timeout;

    logic              w_start_ok;
    logic              w_seed_zero;
    logic              w_sample;
    logic              w_mismatch;
    logic              w_close;
    logic              w_cnt_max;

    assign w_start_ok  = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_seed_zero = (seed == '0);
    assign w_sample    = (r_state == c_st_track) && valid_in;
    assign w_mismatch  = (data_in != r_expected);
    // A recurrence only counts once at least one sample has been taken.
    assign w_close     = (r_count != '0) && (data_in == r_ref_seed);
    assign w_cnt_max   = (r_count == '1);

    // Next-state decode for the measurement FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_nxt = w_seed_zero ? c_st_done : c_st_track;
                end
            end
            c_st_track: begin
                if (valid_in && (w_close || w_cnt_max)) begin
                    w_state_nxt = c_st_done;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // State register plus registered results and tracking datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_ref_seed  <= '0;
            r_expected  <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= '0;
            r_period    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == c_st_track);
            r_done  <= (w_state_nxt == c_st_done);

            if (w_start_ok) begin
                r_err_count <= '0;
                r_period    <= '0;
                r_timeout   <= 1'b0;
                r_count     <= '0;
                if (w_seed_zero) begin
                    // All-zero seed would lock the generator up.
                    r_error <= 1'b1;
                end else begin
                    r_error    <= 1'b0;
                    r_ref_seed <= seed;
                    r_expected <= seed;
                end
            end else if (w_sample) begin
                if (w_mismatch) begin
                    r_error <= 1'b1;
                    if (r_err_count != c_err_max) begin
                        r_err_count <= r_err_count + 16'd1;
                    end
                    // Resync the prediction to the observed stream.
                    r_expected <= f_nxt(data_in);
                end else begin
                    r_expected <= f_nxt(r_expected);
                end

                if (w_close) begin
                    r_period <= r_count;
                end else if (w_cnt_max) begin
                    r_timeout <= 1'b1;
                    r_period  <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign err_count = r_err_count;
    assign period    = r_period;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_checker
//  Description : Directed self-checking bench for lfsr_checker, 4-bit config.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

    logic        clk;
    logic        reset;
    logic [3:0]  seed;
    logic        start;
    logic        valid_in;
    logic [3:0]  data_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] err_count;
    logic [3:0]  period;
    logic        timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Ideal sequence for TAPS=1100 from 0001 (hand-derived).
    logic [3:0] c_seq [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                               4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    // Sample 5 corrupted to 1111, then continues from nxt(1111)=1110.
    logic [3:0] c_bad [10] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'hF, 4'hE, 4'hC,
                               4'h8, 4'h1};

    lfsr_checker #(
        .WIDTH (4),
        .TAPS  (4'b1100)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .seed      (seed),
        .start     (start),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_count (err_count),
        .period    (period),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [3:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [3:0] d);
        valid_in = 1'b1;
        data_in  = d;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total_cnt++;
        if ({busy, done, error, timeout} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {busy, done, error, timeout});
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd0 || period !== 4'd0)
            $display("FAIL reset_values: got err_count=%0d period=%0d want 0/0", err_count, period);
        else pass_cnt++;
    endtask

    task automatic test_zero_seed();
        valid_in = 1'b1;
        data_in  = 4'h0;
        start_run(4'h0);
        total_cnt++;
        if ({done, error, busy, timeout} !== 4'b1100)
            $display("FAIL zero_seed_flags: got done/error/busy/timeout=%b want 1100",
                     {done, error, busy, timeout});
        else pass_cnt++;
        total_cnt++;
        if (period !== 4'd0 || err_count !== 16'd0)
            $display("FAIL zero_seed_values: got period=%0d err_count=%0d want 0/0", period, err_count);
        else pass_cnt++;
    endtask

    task automatic test_ideal();
        start_run(4'h1);
        total_cnt++;
        if ({busy, done, error} !== 3'b100)
            $display("FAIL ideal_start: got busy/done/error=%b want 100", {busy, done, error});
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            feed(c_seq[i]);
            if (i == 14) begin
                total_cnt++;
                if (done !== 1'b0 || busy !== 1'b1)
                    $display("FAIL ideal_early_done: got done=%b busy=%b want 0/1", done, busy);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({done, busy, error, timeout} !== 4'b1000)
            $display("FAIL ideal_flags: got done/busy/error/timeout=%b want 1000",
                     {done, busy, error, timeout});
        else pass_cnt++;
        total_cnt++;
        if (period !== 4'd15 || err_count !== 16'd0)
            $display("FAIL ideal_period: got period=%0d err_count=%0d want 15/0", period, err_count);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (done !== 1'b1 || period !== 4'd15)
            $display("FAIL ideal_hold: got done=%b period=%0d want 1/15", done, period);
        else pass_cnt++;
    endtask

    task automatic test_mismatch();
        start_run(4'h1);
        for (int i = 0; i < 10; i++) begin
            feed(c_bad[i]);
            if (i == 4) begin
                total_cnt++;
                if (error !== 1'b0)
                    $display("FAIL mismatch_pre: got error=%b want 0", error);
                else pass_cnt++;
            end
            if (i == 5) begin
                total_cnt++;
                if (error !== 1'b1 || err_count !== 16'd1)
                    $display("FAIL mismatch_flag: got error=%b err_count=%0d want 1/1", error, err_count);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done !== 1'b1 || period !== 4'd9 || err_count !== 16'd1 || error !== 1'b1)
            $display("FAIL mismatch_result: got done=%b period=%0d err_count=%0d error=%b want 1/9/1/1",
                     done, period, err_count, error);
        else pass_cnt++;
    endtask

    task automatic test_gap();
        start_run(4'h1);
        for (int i = 0; i < 16; i++) begin
            feed(c_seq[i]);
            if (i < 15) tick();
            if (i == 7) begin
                total_cnt++;
                if (busy !== 1'b1 || done !== 1'b0)
                    $display("FAIL gap_mid: got busy=%b done=%b want 1/0", busy, done);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done !== 1'b1 || period !== 4'd15 || error !== 1'b0)
            $display("FAIL gap_result: got done=%b period=%0d error=%b want 1/15/0", done, period, error);
        else pass_cnt++;
    endtask

    task automatic test_stuck();
        start_run(4'h5);
        feed(4'h5);
        total_cnt++;
        if (error !== 1'b0 || done !== 1'b0)
            $display("FAIL stuck_first: got error=%b done=%b want 0/0", error, done);
        else pass_cnt++;
        feed(4'h5);
        total_cnt++;
        if (done !== 1'b1 || period !== 4'd1 || error !== 1'b1 || err_count !== 16'd1)
            $display("FAIL stuck_result: got done=%b period=%0d error=%b err_count=%0d want 1/1/1/1",
                     done, period, error, err_count);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        start_run(4'h1);
        for (int i = 0; i < 16; i++) begin
            feed(4'h3);
            if (i == 14) begin
                total_cnt++;
                if (done !== 1'b0 || timeout !== 1'b0)
                    $display("FAIL timeout_early: got done=%b timeout=%b want 0/0", done, timeout);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done !== 1'b1 || timeout !== 1'b1 || period !== 4'd0)
            $display("FAIL timeout_result: got done=%b timeout=%b period=%0d want 1/1/0",
                     done, timeout, period);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd16 || error !== 1'b1)
            $display("FAIL timeout_errs: got err_count=%0d error=%b want 16/1", err_count, error);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        start_run(4'h1);
        total_cnt++;
        if (timeout !== 1'b0 || error !== 1'b0)
            $display("FAIL restart_clear: got timeout=%b error=%b want 0/0", timeout, error);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) feed(c_seq[i]);
        valid_in = 1'b1;
        data_in  = c_seq[7];
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        valid_in = 1'b0;
        total_cnt++;
        if ({busy, done, error, timeout} !== 4'b0000 || period !== 4'd0 || err_count !== 16'd0)
            $display("FAIL reset_mid: got flags=%b period=%0d err_count=%0d want 0000/0/0",
                     {busy, done, error, timeout}, period, err_count);
        else pass_cnt++;
        feed(c_seq[8]);
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle: got busy=%b done=%b want 0/0", busy, done);
        else pass_cnt++;
        start_run(4'h1);
        for (int i = 0; i < 16; i++) feed(c_seq[i]);
        total_cnt++;
        if (done !== 1'b1 || period !== 4'd15 || error !== 1'b0)
            $display("FAIL reset_rerun: got done=%b period=%0d error=%b want 1/15/0", done, period, error);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        start_run(4'h1);
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 8) begin
                seed  = 4'h5;
                start = 1'b1;
            end
            feed(c_seq[i]);
            start = 1'b0;
        end
        total_cnt++;
        if (done !== 1'b1 || period !== 4'd15 || error !== 1'b0 || err_count !== 16'd0)
            $display("FAIL start_ignored: got done=%b period=%0d error=%b err_count=%0d want 1/15/0/0",
                     done, period, error, err_count);
        else pass_cnt++;
    endtask

    initial begin
        reset    = 1'b0;
        seed     = 4'h0;
        start    = 1'b0;
        valid_in = 1'b0;
        data_in  = 4'h0;
        test_reset();
        test_zero_seed();
        valid_in = 1'b0;
        test_ideal();
        test_mismatch();
        test_gap();
        test_stuck();
        test_timeout();
        test_reset_mid();
        test_start_ignored();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the `lfsr64` generator. It observes the generator's state stream (`shift_seed`) sample by sample and predicts each next state with the same feedback polynomial. It flags and counts any divergence, and measures the sequence period as the number of samples until the seed value recurs. It replaces ad-hoc bench counting with a synthesizable self-check that sits beside the generator in both simulation and hardware.

## Interface
- `WIDTH`, 64: LFSR state width.
- `TAPS`, 64'hD800_0000_0000_0000: feedback mask; bit i set means state bit i feeds the XOR. Must match the generator configuration.
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high; returns the block to IDLE.
- `seed`  in  WIDTH: expected initial state; sampled only on an accepted `start`.
- `start`  in  1: begin a measurement; accepted in IDLE or DONE only.
- `valid_in`  in  1: `data_in` holds a generator state this cycle.
- `data_in`  in  WIDTH: generator state (`shift_seed`).
- `busy`  out  1: high in TRACK.
- `done`  out  1: high in DONE; held until `start` or `reset`.
- `error`  out  1: sticky; at least one mismatch or illegal seed in this run.
- `err_count`  out  16: number of mismatching samples, saturating at 16'hFFFF.
- `period`  out  WIDTH: measured period; valid while `done` is high.
- `timeout`  out  1: run ended because the counter saturated without a recurrence.

## Operation
- Next-state function, Fibonacci left shift: nxt(s) = {s[WIDTH-2:0], ^(s & TAPS)}.
- Internal registers: `ref_seed`, `expected`, `count` (all WIDTH wide), and the FSM state.
- IDLE: all outputs 0. On `start`:
  - If `seed` == 0, go to DONE with `error`=1, `period`=0, `timeout`=0. An all-zero seed is a lock-up state.
  - Otherwise `ref_seed`<=`seed`, `expected`<=`seed`, `count`<=0, `err_count`<=0, `error`<=0, then go to TRACK.
- TRACK, on each cycle with `valid_in`=1 (cycles with `valid_in`=0 change nothing):
  - Compare: if `data_in` != `expected`, set `error`<=1 and increment `err_count` (saturating). Then set `expected`<=nxt(`data_in`), which resyncs to the observed stream. On a match, set `expected`<=nxt(`expected`).
  - Close: if `count` != 0 and `data_in` == `ref_seed`, set `period`<=`count` and go to DONE. This applies whether or not the sample matched.
  - Timeout: otherwise, if `count` == all-ones, set `timeout`<=1, `period`<=0, and go to DONE.
  - Otherwise `count`<=`count`+1.
- DONE: hold all results. A `start` here behaves exactly as a `start` in IDLE, including clearing the results.
- `start` in TRACK is ignored.

## Timing
- All outputs are registered. Reset value of every output is 0.
- The first `valid_in` sample is the first one in a cycle strictly after the `start` cycle. A `valid_in` in the same cycle as `start` is not consumed.
- `error` and `err_count` update on the cycle after the offending sample.
- `done` and `period` appear on the cycle after the closing sample.
- `busy` rises the cycle after `start` and falls in the same cycle that `done` rises.
- `reset` in any state, including mid-TRACK, takes effect at the next edge: state goes to IDLE and all outputs are 0 on the following cycle.
- Throughput: one sample per clock, no back-pressure.

## Test plan
- WIDTH=4, TAPS=4'b1100, seed=4'b0001, ideal generator with `valid_in` always 1: 16 samples 0001,0010,…,1000,0001 -> `done`=1 the cycle after the 16th sample, `period`=15, `error`=0, `err_count`=0, `timeout`=0.
- Same configuration, but sample index 5 is forced to 4'b1111 and the sequence then continues from nxt(1111)=4'b1110 -> `error`=1 and `err_count`=1, with no further mismatches after the resync. The run closes when 0001 recurs, with `period` equal to that sample's index.
- Same configuration, `valid_in` toggling 1,0,1,0,… -> identical `period`=15. `count` does not advance on idle cycles.
- WIDTH=4, stream stuck at 4'b0101, seed=0101 -> every sample after the first mismatches. `err_count` increments each valid cycle. Because `data_in` == `ref_seed` with `count`=1, the run closes on sample 1 with `period`=1 and `error`=1.
- WIDTH=4, seed=0 -> `done`=1 and `error`=1 on the cycle after `start`, `period`=0, and no sample is consumed.
- `reset` asserted at sample 7 of the first scenario -> all outputs 0 and state IDLE the next cycle. A new `start` then yields `period`=15. Separately, `start` pulses during TRACK are ignored, with the same result.
